pht_table: RTL and testbench



---
 rtl/bp_pkg.sv | 16 +
 rtl/pht_table.sv | 78 +++++++
 tb/tb_pht_table.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: counter width and encodings, plus the
// pattern-history-table state type. fsm_for_sel imports the same package.
package bp_pkg;

  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] SNT = 2'b00;
  localparam logic [CNT_W-1:0] WNT = 2'b01;
  localparam logic [CNT_W-1:0] WT  = 2'b10;
  localparam logic [CNT_W-1:0] ST  = 2'b11;

  typedef logic [0:0] pht_state_t;
  localparam pht_state_t PHT_INIT  = 1'b0;
  localparam pht_state_t PHT_READY = 1'b1;

endpackage

// File: rtl/pht_table.sv
// Pattern history table: one 2-bit counter per branch index, self-initialised
// after reset, one-cycle registered read with write-through bypass.
module pht_table
  import bp_pkg::*;
#(
  parameter int               IDX_W    = 6,
  parameter logic [CNT_W-1:0] INIT_VAL = WNT
) (
  input  logic             clk,
  input  logic             reset,
  output logic             init_busy,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_vld,
  output logic [CNT_W-1:0] rd_data,
  output logic             pred_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CNT_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** IDX_W;

  // Handshake: rd_en has no back-pressure; every rd_en accepted in READY
  // produces exactly one rd_vld pulse on the following cycle. wr_en is a
  // fire-and-forget strobe, accepted only in READY.

  pht_state_t             state;
  logic [IDX_W-1:0]       init_ptr;
  logic [CNT_W-1:0]       mem [DEPTH];

  logic                   ready;
  logic                   port_rd;
  logic                   port_wr;

  assign ready      = (state == PHT_READY);
  assign port_rd    = ready && rd_en;
  assign port_wr    = ready && wr_en;
  assign init_busy  = (state == PHT_INIT);
  assign pred_taken = rd_data[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PHT_INIT;
      init_ptr <= '0;
    end else if (state == PHT_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      // The pointer wraps to zero on the same edge the table becomes usable.
      if (init_ptr == {IDX_W{1'b1}}) begin
        state <= PHT_READY;
      end
    end
  end

  // Single write port: init writes and update writes are exclusive by state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == PHT_INIT) begin
        mem[init_ptr] <= INIT_VAL;
      end else if (port_wr) begin
        mem[wr_idx] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= port_rd;
      if (port_rd) begin
        rd_data <= (port_wr && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_pht_table.sv
// Directed plus randomized bench for pht_table against an array-based model
// of the table contents and a saturating-counter model of fsm_for_sel.
module tb_pht_table;
  import bp_pkg::*;

  localparam int IDX_W = 6;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             init_busy;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_vld;
  logic [1:0]       rd_data;
  logic             pred_taken;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] model [DEPTH];
  logic [1:0] exp_q [$];
  logic [1:0] last_data;

  pht_table #(.IDX_W(IDX_W), .INIT_VAL(2'b01)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_vld(rd_vld), .rd_data(rd_data),
    .pred_taken(pred_taken), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 2'b01;
    last_data = 2'b00;
  endtask

  // Pulse reset for one edge, then count init_busy cycles up to a bound.
  task automatic reset_and_count(input string tag);
    int busy_cycles;
    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    busy_cycles = 0;
    while (init_busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      tick();
    end
    check({tag, "_init_cycles"}, 8'(busy_cycles), 8'(DEPTH));
    check({tag, "_init_done"}, 8'(init_busy), 8'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input int idx, input logic [1:0] d);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_data = d;
    tick();
    wr_en = 1'b0;
    model[idx] = d;
  endtask

  task automatic do_read(input string tag, input int idx);
    rd_en = 1'b1; rd_idx = IDX_W'(idx);
    exp_q.push_back(model[idx]);
    tick();
    rd_en = 1'b0;
    scoreboard(tag);
  endtask

  // ---------------- scoreboard ----------------
  task automatic scoreboard(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_vld"}, 8'(rd_vld), 8'd0);
      check({tag, "_hold"}, 8'(rd_data), 8'(last_data));
    end else begin
      e = exp_q.pop_front();
      last_data = e;
      check({tag, "_vld"}, 8'(rd_vld), 8'd1);
      check({tag, "_data"}, 8'(rd_data), 8'(e));
      check({tag, "_pred"}, 8'(pred_taken), 8'(e[1]));
    end
  endtask

  function automatic logic [1:0] sat_next(input logic [1:0] c, input bit torf);
    int v;
    v = int'(c) + (torf ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] cnt;
    reset = 1'b0; rd_en = 1'b0; rd_idx = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    model_reset();

    // reset state
    reset = 1'b1;
    tick();
    check("rst_vld", 8'(rd_vld), 8'd0);
    check("rst_data", 8'(rd_data), 8'd0);
    check("rst_pred", 8'(pred_taken), 8'd0);
    check("rst_busy", 8'(init_busy), 8'd1);
    reset_and_count("init");

    do_read("init_rd0", 0);
    do_read("init_rd31", 31);
    do_read("init_rd63", 63);
    tick();
    scoreboard("idle_after_rd");

    // write then read
    do_write(5, 2'b11);
    do_read("wr_rd5", 5);
    do_read("wr_rd6", 6);

    // collision bypass, then different indices in the same cycle
    rd_en = 1'b1; rd_idx = 6'd9; wr_en = 1'b1; wr_idx = 6'd9; wr_data = 2'b10;
    exp_q.push_back(2'b10); model[9] = 2'b10;
    tick(); rd_en = 1'b0; wr_en = 1'b0;
    scoreboard("bypass_same");
    rd_en = 1'b1; rd_idx = 6'd9; wr_en = 1'b1; wr_idx = 6'd10; wr_data = 2'b11;
    exp_q.push_back(model[9]); model[10] = 2'b11;
    tick(); rd_en = 1'b0; wr_en = 1'b0;
    scoreboard("bypass_diff");
    do_read("diff_wr10", 10);

    // closed loop on idx 3: read -> saturating counter -> write back
    for (int k = 0; k < 7; k++) begin
      bit t;
      t = (k < 4);
      do_read("loop_rd", 3);
      cnt = sat_next(rd_data, t);
      check("loop_model", 8'(cnt), 8'(sat_next(model[3], t)));
      do_write(3, cnt);
    end
    do_read("loop_final", 3);
    check("loop_end_val", 8'(rd_data), 8'(SNT));

    // accesses during INIT are ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      rd_en = 1'b1; rd_idx = 6'd2; wr_en = 1'b1; wr_idx = 6'd2; wr_data = 2'b11;
      tick();
      check("init_ign_vld", 8'(rd_vld), 8'd0);
      check("init_ign_busy", 8'(init_busy), 8'd1);
    end
    rd_en = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 200 && init_busy === 1'b1; c++) tick();
    check("init_ign_ready", 8'(init_busy), 8'd0);
    do_read("init_ign_rd2", 2);

    // reset mid-READY with a read in flight
    do_write(7, 2'b11);
    do_read("pre_rst_rd7", 7);
    rd_en = 1'b1; rd_idx = 6'd7; reset = 1'b1;
    tick();
    rd_en = 1'b0;
    check("midrst_vld", 8'(rd_vld), 8'd0);
    check("midrst_data", 8'(rd_data), 8'd0);
    reset = 1'b0;
    model_reset();
    begin
      int busy_cycles;
      busy_cycles = 0;
      while (init_busy === 1'b1 && busy_cycles < 200) begin
        busy_cycles++;
        tick();
      end
      check("midrst_init_cycles", 8'(busy_cycles), 8'(DEPTH));
    end
    do_read("midrst_rd7", 7);

    // reset mid-INIT restarts the full sequence
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (20) tick();
    reset_and_count("midinit");
    do_read("midinit_rd40", 40);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int ri, wi;
      bit re, we;
      logic [1:0] wd;
      re = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) == 1);
      ri = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      wi = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      wd = 2'($urandom_range(0, 3));
      rd_en = re; rd_idx = IDX_W'(ri); wr_en = we; wr_idx = IDX_W'(wi); wr_data = wd;
      if (re) exp_q.push_back((we && wi == ri) ? wd : model[ri]);
      if (we) model[wi] = wd;
      tick();
      scoreboard("rand");
    end
    rd_en = 1'b0; wr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
